// File: rtl/xorshift_burst_gen.sv
// xorshift_burst_gen
//   Loads a seed on a start handshake and streams xorshift words into a FIFO
//   write port, one per cycle. It stalls on fifo_full without dropping or
//   repeating words. burst_len=0 runs continuously until stop.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start, seed, burst_len      begin a burst (sampled only in IDLE)
//   stop                        abort (honoured only in RUN)
//   fifo_full                   synchronised FIFO full flag
//   out_valid, rand_num         word offered to the FIFO (out_valid is winc)
//   busy, done, count           burst active, end pulse, accepted-word count
module xorshift_burst_gen #(
  parameter int                DATA_W    = 32,
  parameter int                LEN_W     = 16,
  parameter int                SH_A      = 13,
  parameter int                SH_B      = 17,
  parameter int                SH_C      = 5,
  parameter logic [DATA_W-1:0] ZERO_SEED = {{(DATA_W-1){1'b0}}, 1'b1}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              stop,
  input  logic              fifo_full,
  output logic              out_valid,
  output logic [DATA_W-1:0] rand_num,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  count
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_inc;
  logic               acc;
  logic               last;
  logic [DATA_W-1:0]  seed_eff;

  function automatic logic [DATA_W-1:0] xs_step(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] t;
    t = x ^ (x << SH_A);
    t = t ^ (t >> SH_B);
    t = t ^ (t << SH_C);
    return t;
  endfunction

  // An all-zero state is a fixed point of xorshift, so it is replaced.
  assign seed_eff = (seed == '0) ? ZERO_SEED : seed;
  assign cnt_inc  = count + 1'b1;
  // out_valid is high throughout RUN, so an accept is simply ~fifo_full there.
  assign acc      = out_valid & ~fifo_full;
  // len_q==0 selects continuous mode; count wrap never ends the burst.
  assign last     = (len_q != '0) && (cnt_inc == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      out_valid <= 1'b0;
      rand_num  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rand_num  <= xs_step(seed_eff);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            count     <= '0;
            len_q     <= burst_len;
            state     <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            // A word leaving in the abort cycle still counts; rand_num holds.
            if (acc) count <= cnt_inc;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end else if (acc) begin
            count <= cnt_inc;
            if (last) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              rand_num <= xs_step(rand_num);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xorshift_burst_gen.sv
module tb_xorshift_burst_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: default 32-bit / LEN_W=16
  logic        start0 = 0, stop0 = 0, full0 = 0;
  logic [31:0] seed0 = 0;
  logic [15:0] len0 = 0;
  logic        ov0, busy0, done0;
  logic [31:0] rn0;
  logic [15:0] cnt0;

  // dut1: LEN_W=4 for the count wrap check
  logic        start1 = 0, stop1 = 0, full1 = 0;
  logic [31:0] seed1 = 0;
  logic [3:0]  len1 = 0;
  logic        ov1, busy1, done1;
  logic [31:0] rn1;
  logic [3:0]  cnt1;

  // dut2: 64-bit, shifts 13/7/17
  logic        start2 = 0, stop2 = 0, full2 = 0;
  logic [63:0] seed2 = 0;
  logic [15:0] len2 = 0;
  logic        ov2, busy2, done2;
  logic [63:0] rn2;
  logic [15:0] cnt2;

  xorshift_burst_gen u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .seed(seed0), .burst_len(len0),
    .stop(stop0), .fifo_full(full0), .out_valid(ov0), .rand_num(rn0),
    .busy(busy0), .done(done0), .count(cnt0));

  xorshift_burst_gen #(.LEN_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .seed(seed1), .burst_len(len1),
    .stop(stop1), .fifo_full(full1), .out_valid(ov1), .rand_num(rn1),
    .busy(busy1), .done(done1), .count(cnt1));

  xorshift_burst_gen #(.DATA_W(64), .SH_A(13), .SH_B(7), .SH_C(17)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .seed(seed2), .burst_len(len2),
    .stop(stop2), .fifo_full(full2), .out_valid(ov2), .rand_num(rn2),
    .busy(busy2), .done(done2), .count(cnt2));

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [63:0] q2[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Software reference of the xorshift step at width w.
  function automatic logic [63:0] xs(input logic [63:0] x, input int w,
                                     input int a, input int b, input int c);
    logic [63:0] m;
    logic [63:0] y;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    y = x & m;
    y = (y ^ (y << a)) & m;
    y = y ^ (y >> b);
    y = (y ^ (y << c)) & m;
    return y;
  endfunction

  // Push n expected 32-bit words starting from the word after state s.
  task automatic push32(input int which, input logic [31:0] s, input int n);
    logic [63:0] x;
    x = {32'd0, s};
    for (int i = 0; i < n; i++) begin
      x = xs(x, 32, 13, 17, 5);
      if (which == 0) q0.push_back(x[31:0]);
      else            q1.push_back(x[31:0]);
    end
  endtask

  // Monitors: a word is accepted when out_valid & ~fifo_full at the next edge.
  always @(negedge clk) begin
    if (rst_n && ov0 && !full0) begin
      if (q0.size() == 0) chk("dut0_unexpected_word", {32'd0, rn0}, 64'hDEAD);
      else chk("dut0_word", {32'd0, rn0}, {32'd0, q0.pop_front()});
    end
    if (rst_n && ov1 && !full1) begin
      if (q1.size() == 0) chk("dut1_unexpected_word", {32'd0, rn1}, 64'hDEAD);
      else chk("dut1_word", {32'd0, rn1}, {32'd0, q1.pop_front()});
    end
    if (rst_n && ov2 && !full2) begin
      if (q2.size() == 0) chk("dut2_unexpected_word", rn2, 64'hDEAD);
      else chk("dut2_word", rn2, q2.pop_front());
    end
  end

  // Drive start for one edge; returns 1ns after the start edge.
  task automatic start_burst0(input logic [31:0] s, input logic [15:0] l);
    seed0 = s; len0 = l; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("start_busy", {63'd0, busy0}, 64'd1);
    chk("start_valid", {63'd0, ov0}, 64'd1);
  endtask

  task automatic wait_done0(input int budget, output int n);
    n = 0;
    while (!done0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done0) chk("done0_timeout", {63'd0, done0}, 64'd1);
  endtask

  task automatic end_checks0(input string tag, input logic [15:0] exp_cnt);
    chk({tag, "_done"}, {63'd0, done0}, 64'd1);
    chk({tag, "_count"}, {48'd0, cnt0}, {48'd0, exp_cnt});
    chk({tag, "_busy"}, {63'd0, busy0}, 64'd0);
    chk({tag, "_valid"}, {63'd0, ov0}, 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_clear"}, {63'd0, done0}, 64'd0);
    chk({tag, "_count_hold"}, {48'd0, cnt0}, {48'd0, exp_cnt});
  endtask

  initial begin
    int n;
    #12;
    // reset state
    chk("rst_valid", {63'd0, ov0}, 64'd0);
    chk("rst_rand", {32'd0, rn0}, 64'd0);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_done", {63'd0, done0}, 64'd0);
    chk("rst_count", {48'd0, cnt0}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: seed 1, 4 words, no stalls
    q0.push_back(32'h0004_2021);
    q0.push_back(32'h0408_0601);
    push32(0, 32'h0408_0601, 2);
    start_burst0(32'd1, 16'd4);
    chk("t1_first_word", {32'd0, rn0}, 64'h0004_2021);
    wait_done0(20, n);
    chk("t1_cycles", n, 4);
    end_checks0("t1", 16'd4);
    chk("t1_rand_hold", {32'd0, rn0}, {32'd0, xs(xs(64'h0408_0601, 32, 13, 17, 5), 32, 13, 17, 5)});
    chk("t1_queue_empty", q0.size(), 0);

    // T2: same, with 3 stall cycles on the 2nd word
    q0.push_back(32'h0004_2021);
    q0.push_back(32'h0408_0601);
    push32(0, 32'h0408_0601, 2);
    start_burst0(32'd1, 16'd4);
    @(posedge clk); #1;
    full0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_word", {32'd0, rn0}, 64'h0408_0601);
      chk("t2_stall_count", {48'd0, cnt0}, 64'd1);
      @(posedge clk); #1;
    end
    full0 = 1'b0;
    wait_done0(20, n);
    end_checks0("t2", 16'd4);
    chk("t2_queue_empty", q0.size(), 0);

    // T3: zero seed replaced by ZERO_SEED, single word
    q0.push_back(32'h0004_2021);
    start_burst0(32'd0, 16'd1);
    wait_done0(10, n);
    chk("t3_cycles", n, 1);
    end_checks0("t3", 16'd1);

    // T4: continuous, stop in the cycle of the 10th accept
    push32(0, 32'd1, 10);
    start_burst0(32'd1, 16'd0);
    repeat (9) @(posedge clk);
    #1 stop0 = 1'b1;
    @(posedge clk); #1;
    stop0 = 1'b0;
    end_checks0("t4", 16'd10);
    repeat (3) @(posedge clk);
    #1 chk("t4_queue_empty", q0.size(), 0);

    // T4b: count wrap at LEN_W=4 does not end the burst
    push32(1, 32'd1, 17);
    seed1 = 32'd1; len1 = 4'd0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("t4b_wrap_count", {60'd0, cnt1}, 64'd0);
    chk("t4b_wrap_busy", {63'd0, busy1}, 64'd1);
    chk("t4b_wrap_valid", {63'd0, ov1}, 64'd1);
    stop1 = 1'b1;
    @(posedge clk); #1;
    stop1 = 1'b0;
    chk("t4b_done", {63'd0, done1}, 64'd1);
    chk("t4b_count", {60'd0, cnt1}, 64'd1);
    chk("t4b_queue_empty", q1.size(), 0);

    // T5: long burst, ignored start, mid-burst reset, replay
    push32(0, 32'd1, 256);
    start_burst0(32'd1, 16'd256);
    repeat (50) @(posedge clk);
    #1 chk("t5_count50", {48'd0, cnt0}, 64'd50);
    seed0 = 32'h1234; len0 = 16'd3; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("t5_start_ignored_count", {48'd0, cnt0}, 64'd51);
    chk("t5_start_ignored_busy", {63'd0, busy0}, 64'd1);
    repeat (20) @(posedge clk);
    #1 chk("t5_count71", {48'd0, cnt0}, 64'd71);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {63'd0, ov0}, 64'd0);
    chk("t5_rst_rand", {32'd0, rn0}, 64'd0);
    chk("t5_rst_busy", {63'd0, busy0}, 64'd0);
    chk("t5_rst_count", {48'd0, cnt0}, 64'd0);
    chk("t5_rst_done", {63'd0, done0}, 64'd0);
    q0.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    q0.push_back(32'h0004_2021);
    q0.push_back(32'h0408_0601);
    push32(0, 32'h0408_0601, 2);
    start_burst0(32'd1, 16'd4);
    chk("t5_replay_first", {32'd0, rn0}, 64'h0004_2021);
    wait_done0(20, n);
    end_checks0("t5_replay", 16'd4);

    // T6: 64-bit variant
    q2.push_back(64'h0000_0000_4082_2041);
    q2.push_back(xs(64'h0000_0000_4082_2041, 64, 13, 7, 17));
    seed2 = 64'd1; len2 = 16'd2; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("t6_first_word", rn2, 64'h0000_0000_4082_2041);
    n = 0;
    while (!done2 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_done", {63'd0, done2}, 64'd1);
    chk("t6_count", {48'd0, cnt2}, 64'd2);
    chk("t6_queue_empty", q2.size(), 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
